// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU with valid/ready handshake, registered result and status flags.
// Optional unsigned divide/remainder is enabled by defining ALU_DIV_EN.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_cmd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_flags
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
`ifdef ALU_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [4:0] OP_DIVU = 5'd13;
  localparam logic [4:0] OP_REMU = 5'd14;
`endif

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_NOR  = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SLL  = 5'd6;
  localparam logic [4:0] OP_SLA  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9;
  localparam logic [4:0] OP_SLT  = 5'd10;
  localparam logic [4:0] OP_SLTU = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd12;

  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;

  logic             accept;
  logic             cnt_last;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] sc_result;
  logic             sc_c;
  logic             sc_v;
  logic             sc_dz;
  logic             sc_illegal;
  logic             start_mul;
  logic             start_div;
  logic [WIDTH-1:0] mul_acc_nxt;

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign cnt_last = (cnt == {SHW{1'b1}});
  assign shamt    = in_b[SHW-1:0];
  assign add_full = {1'b0, in_a} + {1'b0, in_b};
  assign sub_full = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};

  // op_a holds the shifting multiplicand, op_b the multiplier consumed LSB first
  assign mul_acc_nxt = acc + (op_b[0] ? op_a : {WIDTH{1'b0}});

`ifdef ALU_DIV_EN
  // Restoring step: op_a is the divisor, op_b shifts dividend out and quotient in
  logic             is_rem;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign div_trial = {acc, op_b[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, op_a};
  assign div_ge    = !div_diff[WIDTH];
  assign rem_nxt   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign quo_nxt   = {op_b[WIDTH-2:0], div_ge};
`else
  assign start_div = 1'b0;
`endif

  always_comb begin
    sc_result  = '0;
    sc_c       = 1'b0;
    sc_v       = 1'b0;
    sc_dz      = 1'b0;
    sc_illegal = 1'b0;
    start_mul  = 1'b0;
`ifdef ALU_DIV_EN
    start_div  = 1'b0;
`endif
    case (in_cmd)
      OP_ADD: begin
        sc_result = add_full[WIDTH-1:0];
        sc_c      = add_full[WIDTH];
        sc_v      = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_full[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = sub_full[WIDTH-1:0];
        sc_c      = sub_full[WIDTH];
        sc_v      = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_full[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:         sc_result = in_a & in_b;
      OP_OR:          sc_result = in_a | in_b;
      OP_NOR:         sc_result = ~(in_a | in_b);
      OP_XOR:         sc_result = in_a ^ in_b;
      OP_SLL, OP_SLA: sc_result = in_a << shamt;
      OP_SRL:         sc_result = in_a >> shamt;
      OP_SRA:         sc_result = $unsigned($signed(in_a) >>> shamt);
      OP_SLT:         sc_result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU:        sc_result = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_MUL:         start_mul = 1'b1;
`ifdef ALU_DIV_EN
      // Divide by zero short-circuits to a single-cycle result
      OP_DIVU: begin
        if (in_b == '0) begin
          sc_result = '1;
          sc_dz     = 1'b1;
        end else begin
          start_div = 1'b1;
        end
      end
      OP_REMU: begin
        if (in_b == '0) begin
          sc_result = in_a;
          sc_dz     = 1'b1;
        end else begin
          start_div = 1'b1;
        end
      end
`endif
      default:        sc_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
`ifdef ALU_DIV_EN
      is_rem     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (start_mul) begin
              state     <= S_MUL;
              op_a      <= in_a;
              op_b      <= in_b;
              acc       <= '0;
              cnt       <= '0;
              out_valid <= 1'b0;
            end else if (start_div) begin
`ifdef ALU_DIV_EN
              state     <= S_DIV;
              op_a      <= in_b;
              op_b      <= in_a;
              acc       <= '0;
              cnt       <= '0;
              is_rem    <= (in_cmd == OP_REMU);
              out_valid <= 1'b0;
`endif
            end else begin
              out_result <= sc_result;
              out_flags  <= {sc_illegal, sc_dz, sc_v, sc_c, (sc_result == '0)};
              out_valid  <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          acc  <= mul_acc_nxt;
          op_a <= op_a << 1;
          op_b <= op_b >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt_last) begin
            out_result <= mul_acc_nxt;
            out_flags  <= {4'b0000, (mul_acc_nxt == '0)};
            out_valid  <= 1'b1;
            state      <= S_IDLE;
          end
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          acc  <= rem_nxt;
          op_b <= quo_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt_last) begin
            out_result <= is_rem ? rem_nxt : quo_nxt;
            out_flags  <= {4'b0000, ((is_rem ? rem_nxt : quo_nxt) == '0)};
            out_valid  <= 1'b1;
            state      <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_cmd;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [4:0]   out_flags;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cmd     (in_cmd),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected result, flags {illegal,dz,v,c,z} and latency
  function automatic void refModel(input logic [4:0] cmd, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] res,
                                   output logic [4:0] flg, output int lat);
    longint unsigned ua, ub, ur;
    longint sa, sb, sr;
    logic c, v, dz, ill;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; dz = 1'b0; ill = 1'b0;
    lat = 1;
    res = '0;
    case (cmd)
      5'd0: begin
        ur = ua + ub; res = ur[31:0]; c = (ur >= 64'h1_0000_0000);
        sr = sa + sb; v = (sr > SMAX) || (sr < SMIN);
      end
      5'd1: begin
        ur = ua - ub; res = ur[31:0]; c = (ua >= ub);
        sr = sa - sb; v = (sr > SMAX) || (sr < SMIN);
      end
      5'd2: res = a & b;
      5'd3: res = a | b;
      5'd4: res = ~(a | b);
      5'd5: res = a ^ b;
      5'd6, 5'd7: begin ur = ua << b[4:0]; res = ur[31:0]; end
      5'd8: begin ur = ua >> b[4:0]; res = ur[31:0]; end
      5'd9: begin sr = sa >>> b[4:0]; res = sr[31:0]; end
      5'd10: res = (sa < sb) ? 32'd1 : 32'd0;
      5'd11: res = (ua < ub) ? 32'd1 : 32'd0;
      5'd12: begin ur = ua * ub; res = ur[31:0]; lat = W + 1; end
`ifdef ALU_DIV_EN
      5'd13, 5'd14: begin
        if (b == 0) begin
          dz = 1'b1;
          res = (cmd == 5'd13) ? 32'hFFFF_FFFF : a;
        end else begin
          ur = (cmd == 5'd13) ? (ua / ub) : (ua % ub);
          res = ur[31:0];
          lat = W + 1;
        end
      end
`endif
      default: ill = 1'b1;
    endcase
    flg = {ill, dz, v, c, (res == 0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one op, wait for its result; returns observed result, flags and latency
  task automatic applyStimulus(input logic [4:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] res, output logic [4:0] flg, output int lat);
    int busy_bad;
    @(negedge clk);
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    lat      = 0;
    busy_bad = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready !== 1'b0) busy_bad++;
      in_a = $urandom;
      in_b = $urandom;
    end
    checkOutput("in_ready_low_while_busy", busy_bad, 32'd0);
    res = out_result;
    flg = out_flags;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
  endtask

  task automatic backToBack(input int n);
    logic [4:0]   c;
    logic [W-1:0] a, b, er;
    logic [4:0]   ef;
    int           el;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      c = 5'($urandom_range(0, 11));
      if (i == n - 1) c = 5'd20;
      a = $urandom;
      b = $urandom;
      checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_cmd   = c;
      in_a     = a;
      in_b     = b;
      @(negedge clk);
      refModel(c, a, b, er, ef, el);
      checkOutput("b2b_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("b2b_result", out_result, er);
      checkOutput("b2b_flags", {27'd0, out_flags}, {27'd0, ef});
    end
    in_valid = 1'b0;
  endtask

  logic [W-1:0] r, er;
  logic [4:0]   f, ef;
  int           l, el, stale;
  logic [4:0]   rc;
  logic [W-1:0] ra, rb;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cmd    = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_out_result", out_result, 32'd0);
    checkOutput("reset_out_flags", {27'd0, out_flags}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(5'd0, 32'hFFFF_FFFF, 32'd1, r, f, l);
    checkOutput("add_result", r, 32'd0);
    checkOutput("add_flags", {27'd0, f}, 32'b00011);
    checkOutput("add_latency", l, 32'd1);

    applyStimulus(5'd1, 32'h8000_0000, 32'd1, r, f, l);
    checkOutput("sub_result", r, 32'h7FFF_FFFF);
    checkOutput("sub_flags", {27'd0, f}, 32'b00110);

    applyStimulus(5'd9, 32'h8000_0000, 32'h24, r, f, l);
    checkOutput("sra_result", r, 32'hF800_0000);
    checkOutput("sra_flags", {27'd0, f}, 32'd0);

    applyStimulus(5'd10, 32'hFFFF_FFFF, 32'd1, r, f, l);
    checkOutput("slt_result", r, 32'd1);
    applyStimulus(5'd11, 32'hFFFF_FFFF, 32'd1, r, f, l);
    checkOutput("sltu_result", r, 32'd0);
    checkOutput("sltu_flags", {27'd0, f}, 32'b00001);

    applyStimulus(5'd20, 32'h1234, 32'h5678, r, f, l);
    checkOutput("illegal_result", r, 32'd0);
    checkOutput("illegal_flags", {27'd0, f}, 32'b10001);
    checkOutput("illegal_latency", l, 32'd1);

    applyStimulus(5'd12, 32'h0001_2345, 32'h0000_1000, r, f, l);
    checkOutput("mul_result", r, 32'h1234_5000);
    checkOutput("mul_latency", l, 32'd33);

`ifdef ALU_DIV_EN
    applyStimulus(5'd13, 32'd100, 32'd7, r, f, l);
    checkOutput("divu_result", r, 32'd14);
    checkOutput("divu_latency", l, 32'd33);
    applyStimulus(5'd14, 32'd100, 32'd7, r, f, l);
    checkOutput("remu_result", r, 32'd2);
    applyStimulus(5'd13, 32'd5, 32'd0, r, f, l);
    checkOutput("divu0_result", r, 32'hFFFF_FFFF);
    checkOutput("divu0_flags", {27'd0, f}, 32'b01000);
    checkOutput("divu0_latency", l, 32'd1);
    applyStimulus(5'd14, 32'd5, 32'd0, r, f, l);
    checkOutput("remu0_result", r, 32'd5);
`else
    applyStimulus(5'd13, 32'd100, 32'd7, r, f, l);
    checkOutput("divu_nodiv_result", r, 32'd0);
    checkOutput("divu_nodiv_flags", {27'd0, f}, 32'b10001);
    checkOutput("divu_nodiv_latency", l, 32'd1);
`endif

    backToBack(6);

    // Output must hold while the consumer stalls
    drain();
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(5'd12, 32'h0001_2345, 32'h0000_1000, r, f, l);
    checkOutput("hold_mul_latency", l, 32'd33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_result", out_result, 32'h1234_5000);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;

    for (int i = 0; i < 40; i++) begin
      rc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(12, 14)) : 5'($urandom_range(0, 31));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      applyStimulus(rc, ra, rb, r, f, l);
      refModel(rc, ra, rb, er, ef, el);
      checkOutput($sformatf("rand_result_cmd%0d", rc), r, er);
      checkOutput($sformatf("rand_flags_cmd%0d", rc), {27'd0, f}, {27'd0, ef});
      checkOutput($sformatf("rand_latency_cmd%0d", rc), l, el);
    end

    // Reset in the middle of a multiply must abort it without a result
    drain();
    @(negedge clk);
    in_valid = 1'b1;
    in_cmd   = 5'd12;
    in_a     = 32'h0000_0003;
    in_b     = 32'h0000_0005;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_out_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("rst_no_stale_result", stale, 32'd0);
    checkOutput("rst_in_ready_after", {31'd0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the processor's combinational ALU; sits in the EX stage.
- Adds a valid/ready handshake, a registered result and a status-flag word.
- Adds set-less-than and iterative multiply; unsigned divide/remainder is optional.
- Single-cycle ops return in 1 cycle; MUL/DIV hold the pipeline through the handshake.

Parameters:
- WIDTH, 32, operand/result width (power of 2, >= 8)
- SHW, $clog2(WIDTH), shift-amount bits taken from in_b[SHW-1:0]

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept an operation this cycle
- in_cmd  input  5  opcode
- in_a  input  WIDTH  operand 1
- in_b  input  WIDTH  operand 2
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  result
- out_flags  output  5  {illegal, dz, v, c, z}

Behaviour:
- Reset: the already-decided single clock is clk; reset is rst_n, asynchronous, active-low. Reset values: state=IDLE, out_valid=0, out_result=0, out_flags=0, in_ready=1 once released, internal counters cleared.
- Reset mid-MUL/DIV aborts the operation; no result is produced.
- Opcodes 0-9:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR.
  - 6 SLL, 7 SLA (identical to SLL).
  - 8 SRL (logical), 9 SRA (arithmetic, sign of in_a).
  - Shift amount is in_b[SHW-1:0] only.
- Opcodes 10-14:
  - 10 SLT: signed, result 1 or 0.
  - 11 SLTU: unsigned, result 1 or 0.
  - 12 MUL: low WIDTH bits of the product.
  - 13 DIVU: unsigned quotient.
  - 14 REMU: unsigned remainder.
- Opcodes 15-31 are illegal: result 0, illegal=1, 1-cycle latency.
- Flags:
  - z = (result==0) for every op.
  - c: carry-out for ADD, NOT borrow for SUB, 0 otherwise.
  - v: signed overflow for ADD/SUB, 0 otherwise.
  - dz = 1 only for DIVU/REMU with in_b==0.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - out_valid holds, with out_result/out_flags stable, until out_ready. The output is consumed on out_valid && out_ready.
  - Simultaneous consume and accept of a single-cycle op in the same cycle: the new result appears next cycle with no bubble.
- FSM IDLE -> MUL/DIV -> IDLE:
  - IDLE: a single-cycle op registers its result; out_valid=1 the next cycle (latency 1). MUL or DIV captures operands, clears the counter and enters the matching state.
  - MUL: shift-add, one bit of in_b per cycle, WIDTH cycles. The last iteration writes out_result, sets out_valid and returns to IDLE. Latency WIDTH+1 from accept.
  - DIV: restoring divide, one quotient bit per cycle, WIDTH cycles, same latency as MUL.
  - DIV with in_b==0 skips the iterations: 1-cycle latency, DIVU result all-ones, REMU result = in_a, dz=1.
- in_ready is 0 throughout MUL/DIV; inputs are ignored there.
- Arithmetic is modulo 2^WIDTH; operands are captured at accept, so later input changes have no effect.

Optional Feature:
- ALU_DIV_EN defined: DIVU/REMU are implemented as described above.
- ALU_DIV_EN undefined: the DIV state and datapath are absent; opcodes 13/14 behave as illegal (result 0, illegal=1, latency 1).

Test Plan:
- WIDTH=32, ADD a=0xFFFFFFFF b=1, out_ready=1 -> next cycle result=0, z=1, c=1, v=0. Back-to-back accept proceeds with no bubble.
- SUB a=0x80000000 b=1 -> result=0x7FFFFFFF, v=1, c=1. SRA a=0x80000000 b=0x24 -> result=0xF8000000 (shift 4).
- MUL a=0x00012345 b=0x00001000 -> in_ready=0 for 32 cycles; out_valid at cycle 33 with result=0x12345000. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
- With ALU_DIV_EN: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF, dz=1, latency 1. Without ALU_DIV_EN: DIVU -> 0, illegal=1.
- Opcode 20 -> result 0, illegal=1. SLT a=-1 b=1 -> 1; SLTU a=-1 b=1 -> 0.
- Assert rst_n=0 mid-MUL, cycle 10 -> out_valid=0 immediately; after release in_ready=1 and no stale result appears.
